ccw_seq: RTL and testbench
==========================

CCW_SEQ -- requirements
Module: ccw_seq

Interface
REQ-001 SHALL provide parameter ADR_W, default 22, width of the memory word address (bits 14..35).
REQ-002 SHALL provide parameter WC_W, default 11, width of the word count.
REQ-003 SHALL provide parameter DEPTH, default 4, data buffer depth; legal values are powers of 2, 2..16.
REQ-004 SHALL have port clk_ccw_h, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port ch_mr_reset_l, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port ccw_load_h, input, 1 bit: one-cycle strobe that loads a new CCW.
REQ-007 SHALL have ports ccw_wc_h (input, WC_W), ccw_adr_h (input, ADR_W) and ccw_chan_to_mem_h (input, 1): CCW count, start address and direction.
REQ-008 SHALL have ports chan_in_vld_h (input, 1), chan_in_rdy_h (output, 1) and chan_in_d_h (input, 36): channel-to-buffer data.
REQ-009 SHALL have ports chan_out_vld_h (output, 1), chan_out_rdy_h (input, 1) and chan_out_d_h (output, 36): buffer-to-channel data.
REQ-010 SHALL have ports mem_req_h (output, 1), mem_wr_h (output, 1), mem_adr_h (output, ADR_W), mem_wd_h (output, 36), mem_ack_h (input, 1) and mem_rd_h (input, 36): memory port.
REQ-011 SHALL have outputs ccw_busy_h (1), ccwf_req_h (1) and buf_cnt_h ($clog2(DEPTH)+1): status.

Function
REQ-012 SHALL use states IDLE, XFER, DRAIN and FETCH; IDLE -> XFER on ccw_load_h with ccw_wc_h != 0; IDLE -> FETCH on ccw_load_h with ccw_wc_h == 0.
REQ-013 SHALL ignore ccw_load_h in every state except IDLE and FETCH; a load in FETCH behaves as a load in IDLE.
REQ-014 SHALL, at load, latch the address into an address register and the count into both a memory count (mcnt) and a channel count (ccnt).
REQ-015 SHALL, for chan_to_mem=1, assert chan_in_rdy_h when the buffer is not full and ccnt != 0, push on vld&rdy, and decrement ccnt on each push.
REQ-016 SHALL, for chan_to_mem=1, assert mem_req_h with mem_wr_h=1 while the buffer is non-empty and mcnt != 0, present the buffer head on mem_wd_h, and pop on mem_ack_h.
REQ-017 SHALL, for chan_to_mem=0, assert mem_req_h with mem_wr_h=0 while mcnt != 0 and the buffer is not full, and push mem_rd_h on mem_ack_h.
REQ-018 SHALL, for chan_to_mem=0, drive chan_out_vld_h while the buffer is non-empty, pop on vld&rdy, and decrement ccnt on each pop.
REQ-019 SHALL have at most one memory request outstanding; once asserted, mem_req_h, mem_wr_h, mem_adr_h and mem_wd_h hold stable until mem_ack_h.
REQ-020 SHALL, on each mem_ack_h, increment the address modulo 2^ADR_W (all-ones wraps to 0) and decrement mcnt.
REQ-021 SHALL enter DRAIN when mcnt reaches 0 and the buffer is still non-empty, and go to FETCH when mcnt == 0, ccnt == 0 and the buffer is empty.
REQ-022 SHALL allow a push and a pop in the same cycle on a full or an empty buffer; buf_cnt_h is then unchanged.
REQ-023 SHALL assert ccwf_req_h throughout FETCH; ccw_busy_h SHALL be 1 in XFER and DRAIN only.
REQ-024 SHALL take one cycle from ack to the next request, so the sustained rate is one word per two cycles.

Reset
REQ-025 SHALL, while ch_mr_reset_l=0, force state IDLE, flush the buffer, and clear all counts and the address register.
REQ-026 SHALL hold every output at 0 during reset and in IDLE, including buf_cnt_h and mem_adr_h.
REQ-027 SHALL, on reset mid-transfer, abandon the outstanding request; a mem_ack_h arriving during IDLE SHALL be ignored.

Configuration
REQ-028 SHALL, with CCW_ZERO_FILL_EN defined, add input ccw_zero_fill_h, sampled at load; when it is set with chan_to_mem=1, mem_wd_h is 36'b0 and the channel words are still consumed.
REQ-029 SHALL, without CCW_ZERO_FILL_EN, have no ccw_zero_fill_h port, and mem_wd_h always equals the buffer head.

Verification
REQ-030 SHALL cover: load wc=3, adr=0o1000, chan_to_mem=1, words A,B,C -> writes to 0o1000..0o1002 with A,B,C; then FETCH and ccwf_req_h=1.
REQ-031 SHALL cover: load wc=5, chan_to_mem=0, chan_out_rdy_h=0 -> exactly DEPTH=4 reads, then mem_req_h=0 until the channel pops.
REQ-032 SHALL cover: load adr=2^22-1, wc=2 -> writes to 0o17777777 then 0.
REQ-033 SHALL cover: load wc=0 -> FETCH next cycle, no mem_req_h.
REQ-034 SHALL cover: reset asserted with mem_req_h high and buffer holding 2 -> all outputs 0 immediately; an ack after release is ignored.
REQ-035 SHALL cover: with CCW_ZERO_FILL_EN defined, zero_fill=1, wc=2 -> two writes of 0, and two channel words consumed.

Source files
------------

// File: rtl/ccw_seq.sv
// ccw_seq: channel command word sequencer. It moves one CCW's worth of 36-bit words
// between a channel port and memory through a DEPTH-entry buffer.
// Optional build macro CCW_ZERO_FILL_EN adds ccw_zero_fill_h: when it is set at load
// with chan_to_mem=1, memory writes carry zeros while channel words are still consumed.
module ccw_seq #(
    parameter int unsigned ADR_W = 22,
    parameter int unsigned WC_W  = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_ccw_h,
    input  logic                    ch_mr_reset_l,
    input  logic                    ccw_load_h,
    input  logic [WC_W-1:0]         ccw_wc_h,
    input  logic [ADR_W-1:0]        ccw_adr_h,
    input  logic                    ccw_chan_to_mem_h,
`ifdef CCW_ZERO_FILL_EN
    input  logic                    ccw_zero_fill_h,
`endif
    input  logic                    chan_in_vld_h,
    output logic                    chan_in_rdy_h,
    input  logic [35:0]             chan_in_d_h,
    output logic                    chan_out_vld_h,
    input  logic                    chan_out_rdy_h,
    output logic [35:0]             chan_out_d_h,
    output logic                    mem_req_h,
    output logic                    mem_wr_h,
    output logic [ADR_W-1:0]        mem_adr_h,
    output logic [35:0]             mem_wd_h,
    input  logic                    mem_ack_h,
    input  logic [35:0]             mem_rd_h,
    output logic                    ccw_busy_h,
    output logic                    ccwf_req_h,
    output logic [$clog2(DEPTH):0]  buf_cnt_h
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StXfer, StDrain, StFetch} state_e;

    state_e           state_q, state_d;
    logic [ADR_W-1:0] adr_q;
    logic [WC_W-1:0]  mcnt_q;
    logic [WC_W-1:0]  ccnt_q;
    logic             dir_q;
    logic             req_q, req_d;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [35:0]      buf_q [DEPTH];

    logic        active, load_ok, full, empty, ack;
    logic        push, pop, req_raise, ccnt_dec, zf_act;
    logic [35:0] head, push_data;

    assign active  = (state_q == StXfer) || (state_q == StDrain);
    assign load_ok = ccw_load_h && ((state_q == StIdle) || (state_q == StFetch));
    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    // An ack with nothing outstanding (e.g. right after reset) is ignored.
    assign ack     = req_q && mem_ack_h;
    assign head    = buf_q[rd_ptr_q];

`ifdef CCW_ZERO_FILL_EN
    logic zf_q;

    // Zero-fill mode is captured with the CCW and only matters for writes.
    always_ff @(posedge clk_ccw_h or negedge ch_mr_reset_l) begin
        if (!ch_mr_reset_l) begin
            zf_q <= 1'b0;
        end else if (load_ok) begin
            zf_q <= ccw_zero_fill_h;
        end
    end

    assign zf_act = zf_q && dir_q;
`else
    assign zf_act = 1'b0;
`endif

    // Buffer push/pop sources depend on direction; memory side always uses the ack.
    always_comb begin
        push      = dir_q ? (chan_in_vld_h && chan_in_rdy_h) : ack;
        push_data = dir_q ? chan_in_d_h : mem_rd_h;
        pop       = dir_q ? ack : (chan_out_vld_h && chan_out_rdy_h);
        ccnt_dec  = dir_q ? push : pop;
        // Only raise a request when the buffer can supply (write) or absorb (read) a word.
        req_raise = active && !req_q && (mcnt_q != '0) && (dir_q ? !empty : !full);
        // Drop for one cycle after each ack, then re-evaluate.
        req_d     = req_q ? !ack : req_raise;
        cnt_d     = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Data buffer storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk_ccw_h or negedge ch_mr_reset_l) begin
        if (!ch_mr_reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // CCW registers: address, memory/channel counts, direction and request flag.
    always_ff @(posedge clk_ccw_h or negedge ch_mr_reset_l) begin
        if (!ch_mr_reset_l) begin
            adr_q  <= '0;
            mcnt_q <= '0;
            ccnt_q <= '0;
            dir_q  <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            req_q <= req_d;
            if (load_ok) begin
                adr_q  <= ccw_adr_h;
                mcnt_q <= ccw_wc_h;
                ccnt_q <= ccw_wc_h;
                dir_q  <= ccw_chan_to_mem_h;
            end else begin
                if (ack) begin
                    adr_q  <= adr_q + ADR_W'(1);
                    mcnt_q <= mcnt_q - WC_W'(1);
                end
                if (ccnt_dec) begin
                    ccnt_q <= ccnt_q - WC_W'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_ccw_h or negedge ch_mr_reset_l) begin
        if (!ch_mr_reset_l) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: finish once memory side is done and the buffer has emptied.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StFetch: begin
                if (ccw_load_h) begin
                    state_d = (ccw_wc_h != '0) ? StXfer : StFetch;
                end
            end
            StXfer: begin
                if (mcnt_q == '0) begin
                    if (!empty) begin
                        state_d = StDrain;
                    end else if (ccnt_q == '0) begin
                        state_d = StFetch;
                    end
                end
            end
            StDrain: begin
                if (empty && (ccnt_q == '0)) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: everything is forced low in IDLE.
    always_comb begin
        chan_in_rdy_h  = 1'b0;
        chan_out_vld_h = 1'b0;
        chan_out_d_h   = '0;
        mem_req_h      = 1'b0;
        mem_wr_h       = 1'b0;
        mem_adr_h      = '0;
        mem_wd_h       = '0;
        ccw_busy_h     = active;
        ccwf_req_h     = (state_q == StFetch);
        buf_cnt_h      = cnt_q;
        if (state_q != StIdle) begin
            chan_in_rdy_h  = active && dir_q && !full && (ccnt_q != '0);
            chan_out_vld_h = active && !dir_q && !empty;
            chan_out_d_h   = head;
            mem_req_h      = req_q;
            mem_wr_h       = req_q && dir_q;
            mem_adr_h      = adr_q;
            mem_wd_h       = zf_act ? 36'b0 : head;
        end
    end

endmodule

// File: tb/tb_ccw_seq.sv
// tb_ccw_seq: randomized scoreboard bench for ccw_seq. Load-time model pushes expected
// memory writes / reads / channel output words; a monitor pops them on each handshake.
module tb_ccw_seq;

    localparam int unsigned ADR_W = 22;
    localparam int unsigned WC_W  = 11;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [21:0] adr;
        logic [35:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ccw_load_h;
    logic [10:0] ccw_wc_h;
    logic [21:0] ccw_adr_h;
    logic        ccw_chan_to_mem_h;
`ifdef CCW_ZERO_FILL_EN
    logic        zf_in;
`endif
    logic        chan_in_vld_h, chan_in_rdy_h;
    logic [35:0] chan_in_d_h;
    logic        chan_out_vld_h, chan_out_rdy_h;
    logic [35:0] chan_out_d_h;
    logic        mem_req_h, mem_wr_h, mem_ack_h;
    logic [21:0] mem_adr_h;
    logic [35:0] mem_wd_h, mem_rd_h;
    logic        ccw_busy_h, ccwf_req_h;
    logic [2:0]  buf_cnt_h;

    int total = 0;
    int bad   = 0;
    int rd_acks = 0;
    int wr_acks = 0;
    bit resp_en  = 1'b1;
    bit out_hold = 1'b0;

    wr_t         exp_wr[$];
    logic [21:0] exp_rdadr[$];
    logic [35:0] exp_out[$];
    logic [35:0] in_q[$];
    logic [35:0] wbuf[$];

    always #5 clk = ~clk;

    ccw_seq #(.ADR_W(ADR_W), .WC_W(WC_W), .DEPTH(DEPTH)) dut (
        .clk_ccw_h        (clk),
        .ch_mr_reset_l    (rst_n),
        .ccw_load_h       (ccw_load_h),
        .ccw_wc_h         (ccw_wc_h),
        .ccw_adr_h        (ccw_adr_h),
        .ccw_chan_to_mem_h(ccw_chan_to_mem_h),
`ifdef CCW_ZERO_FILL_EN
        .ccw_zero_fill_h  (zf_in),
`endif
        .chan_in_vld_h    (chan_in_vld_h),
        .chan_in_rdy_h    (chan_in_rdy_h),
        .chan_in_d_h      (chan_in_d_h),
        .chan_out_vld_h   (chan_out_vld_h),
        .chan_out_rdy_h   (chan_out_rdy_h),
        .chan_out_d_h     (chan_out_d_h),
        .mem_req_h        (mem_req_h),
        .mem_wr_h         (mem_wr_h),
        .mem_adr_h        (mem_adr_h),
        .mem_wd_h         (mem_wd_h),
        .mem_ack_h        (mem_ack_h),
        .mem_rd_h         (mem_rd_h),
        .ccw_busy_h       (ccw_busy_h),
        .ccwf_req_h       (ccwf_req_h),
        .buf_cnt_h        (buf_cnt_h)
    );

    // Memory contents as seen by reads: a fixed function of the address.
    function automatic logic [35:0] mem_word(input logic [21:0] a);
        return {a[13:0] ^ 14'h1abc, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s (unexpected event) t=%0t", nm, $time);
    endtask

    task automatic samp();
        @(negedge clk);
        #4;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_mem_req"}, 64'(mem_req_h), 64'd0);
        chk({nm, "_mem_wr"}, 64'(mem_wr_h), 64'd0);
        chk({nm, "_mem_adr"}, 64'(mem_adr_h), 64'd0);
        chk({nm, "_mem_wd"}, 64'(mem_wd_h), 64'd0);
        chk({nm, "_in_rdy"}, 64'(chan_in_rdy_h), 64'd0);
        chk({nm, "_out_vld"}, 64'(chan_out_vld_h), 64'd0);
        chk({nm, "_out_d"}, 64'(chan_out_d_h), 64'd0);
        chk({nm, "_busy"}, 64'(ccw_busy_h), 64'd0);
        chk({nm, "_ccwf"}, 64'(ccwf_req_h), 64'd0);
        chk({nm, "_buf_cnt"}, 64'(buf_cnt_h), 64'd0);
    endtask

    // Issue a CCW and record what it must produce: word i goes to/from address adr+i mod 2^22.
    task automatic load_ccw(input bit dir, input int unsigned wc, input logic [21:0] adr,
                            input bit zf);
        logic [21:0] a;
        wr_t         e;
        a = adr;
        @(negedge clk);
        ccw_load_h        = 1'b1;
        ccw_wc_h          = 11'(wc);
        ccw_adr_h         = adr;
        ccw_chan_to_mem_h = dir;
`ifdef CCW_ZERO_FILL_EN
        zf_in = zf;
`endif
        for (int unsigned i = 0; i < wc; i++) begin
            if (dir) begin
                e.adr = a;
                e.d   = zf ? 36'd0 : wbuf[i];
                exp_wr.push_back(e);
                in_q.push_back(wbuf[i]);
            end else begin
                exp_rdadr.push_back(a);
                exp_out.push_back(mem_word(a));
            end
            a = a + 22'd1;
        end
        wbuf.delete();
        @(negedge clk);
        ccw_load_h = 1'b0;
    endtask

    task automatic rand_words(input int unsigned n);
        logic [35:0] w;
        for (int unsigned i = 0; i < n; i++) begin
            w[31:0]  = $urandom();
            w[35:32] = 4'($urandom_range(15, 0));
            wbuf.push_back(w);
        end
    endtask

    task automatic wait_fetch(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            samp();
            n++;
        end while (!ccwf_req_h && n < budget);
        chk({nm, "_fetch"}, 64'(ccwf_req_h), 64'd1);
        chk({nm, "_busy"}, 64'(ccw_busy_h), 64'd0);
        chk({nm, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        chk({nm, "_rd_left"}, 64'(exp_out.size()), 64'd0);
        chk({nm, "_in_left"}, 64'(in_q.size()), 64'd0);
    endtask

    // Stimulus driver: memory responder with random latency, channel source and sink.
    initial begin
        int unsigned dly;
        dly = 0;
        forever begin
            @(negedge clk);
            mem_ack_h = 1'b0;
            if (resp_en && mem_req_h) begin
                if (dly == 0) begin
                    mem_ack_h = 1'b1;
                    mem_rd_h  = mem_word(mem_adr_h);
                    dly       = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
            if (in_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                chan_in_vld_h = 1'b1;
                chan_in_d_h   = in_q[0];
            end else begin
                chan_in_vld_h = 1'b0;
            end
            chan_out_rdy_h = !out_hold && ($urandom_range(0, 2) != 0);
            #4;
            if (chan_in_vld_h && chan_in_rdy_h && in_q.size() > 0) begin
                void'(in_q.pop_front());
            end
        end
    end

    // Monitor: scoreboard pops on every handshake plus request-hold and bubble checks.
    initial begin
        bit          p_req, p_ack, p_wr;
        logic [21:0] p_adr;
        logic [35:0] p_wd;
        wr_t         e;
        p_req = 1'b0;
        p_ack = 1'b0;
        p_wr  = 1'b0;
        p_adr = '0;
        p_wd  = '0;
        forever begin
            samp();
            if (!rst_n) begin
                p_req = 1'b0;
                p_ack = 1'b0;
                continue;
            end
            if (p_req && !p_ack) begin
                chk("hold_req", 64'(mem_req_h), 64'd1);
                chk("hold_wr", 64'(mem_wr_h), 64'(p_wr));
                chk("hold_adr", 64'(mem_adr_h), 64'(p_adr));
                if (p_wr) chk("hold_wd", 64'(mem_wd_h), 64'(p_wd));
            end
            if (p_req && p_ack) chk("ack_bubble", 64'(mem_req_h), 64'd0);
            if (mem_req_h && mem_ack_h) begin
                if (mem_wr_h) begin
                    wr_acks++;
                    if (exp_wr.size() == 0) begin
                        fail_now("wr_extra");
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_adr", 64'(mem_adr_h), 64'(e.adr));
                        chk("wr_data", 64'(mem_wd_h), 64'(e.d));
                    end
                end else begin
                    rd_acks++;
                    if (exp_rdadr.size() == 0) fail_now("rd_extra");
                    else chk("rd_adr", 64'(mem_adr_h), 64'(exp_rdadr.pop_front()));
                end
            end
            if (chan_out_vld_h && chan_out_rdy_h) begin
                if (exp_out.size() == 0) fail_now("out_extra");
                else chk("out_data", 64'(chan_out_d_h), 64'(exp_out.pop_front()));
            end
            p_req = mem_req_h;
            p_ack = mem_ack_h;
            p_wr  = mem_wr_h;
            p_adr = mem_adr_h;
            p_wd  = mem_wd_h;
        end
    end

    // Main sequence.
    initial begin
        bit          dir;
        int unsigned wc;
        logic [21:0] adr;
        int          n;
        rst_n             = 1'b0;
        ccw_load_h        = 1'b0;
        ccw_wc_h          = '0;
        ccw_adr_h         = '0;
        ccw_chan_to_mem_h = 1'b0;
`ifdef CCW_ZERO_FILL_EN
        zf_in = 1'b0;
`endif
        chan_in_vld_h  = 1'b0;
        chan_in_d_h    = '0;
        chan_out_rdy_h = 1'b0;
        mem_ack_h      = 1'b0;
        mem_rd_h       = '0;

        repeat (3) samp();
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        samp();
        chk_idle("idle");

        // wc=0 from IDLE goes straight to FETCH with no memory traffic.
        load_ccw(1'b1, 0, 22'o123, 1'b0);
        #4;
        chk("wc0_fetch", 64'(ccwf_req_h), 64'd1);
        chk("wc0_busy", 64'(ccw_busy_h), 64'd0);
        for (int i = 0; i < 5; i++) begin
            samp();
            chk("wc0_noreq", 64'(mem_req_h), 64'd0);
        end

        // Three known words to 0o1000..0o1002.
        wr_acks = 0;
        wbuf.push_back(36'h0a0a0a0a0);
        wbuf.push_back(36'h0b0b0b0b0);
        wbuf.push_back(36'h0c0c0c0c0);
        load_ccw(1'b1, 3, 22'o1000, 1'b0);
        wait_fetch("w3", 500);
        chk("w3_acks", 64'(wr_acks), 64'd3);

        // Address wraps from all-ones to zero.
        rand_words(2);
        load_ccw(1'b1, 2, 22'h3fffff, 1'b0);
        wait_fetch("wrap", 500);

        // Read with channel stalled: exactly DEPTH reads, then no request.
        rd_acks  = 0;
        out_hold = 1'b1;
        load_ccw(1'b0, 5, 22'($urandom()), 1'b0);
        repeat (60) samp();
        chk("stall_reads", 64'(rd_acks), 64'(DEPTH));
        chk("stall_cnt", 64'(buf_cnt_h), 64'(DEPTH));
        chk("stall_noreq", 64'(mem_req_h), 64'd0);
        chk("stall_busy", 64'(ccw_busy_h), 64'd1);
        chk("stall_vld", 64'(chan_out_vld_h), 64'd1);
        out_hold = 1'b0;
        wait_fetch("stall", 500);
        chk("stall_reads_all", 64'(rd_acks), 64'd5);

        // Random CCWs of both directions.
        for (int k = 0; k < 12; k++) begin
            dir = 1'($urandom_range(0, 1));
            wc  = $urandom_range(1, 12);
            adr = (k == 3) ? 22'h3ffffd : 22'($urandom());
            if (dir) rand_words(wc);
            load_ccw(dir, wc, adr, 1'b0);
            wait_fetch("rand", 3000);
        end

`ifdef CCW_ZERO_FILL_EN
        wr_acks = 0;
        rand_words(2);
        load_ccw(1'b1, 2, 22'o777, 1'b1);
        wait_fetch("zfill", 500);
        chk("zfill_acks", 64'(wr_acks), 64'd2);
`endif

        // Reset with a request pending and two words buffered.
        resp_en = 1'b0;
        rand_words(4);
        load_ccw(1'b1, 4, 22'o4000, 1'b0);
        while (in_q.size() > 2) void'(in_q.pop_back());
        n = 0;
        do begin
            samp();
            n++;
        end while (!(mem_req_h && buf_cnt_h == 3'd2) && n < 200);
        chk("rst_setup_req", 64'(mem_req_h), 64'd1);
        chk("rst_setup_cnt", 64'(buf_cnt_h), 64'd2);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        exp_wr.delete();
        in_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        mem_ack_h = 1'b1;
        @(negedge clk);
        #2;
        mem_ack_h = 1'b0;
        samp();
        chk_idle("stray_ack");
        resp_en = 1'b1;

        // Recovery after reset.
        rand_words(3);
        load_ccw(1'b1, 3, 22'o7000, 1'b0);
        wait_fetch("recover", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
